// File: rtl/logic_accum.sv
// Registered bitwise reducer (OR/AND/XOR/NOR) over in_last-delimited packets, one result per packet.
// Optional beat-count output enabled by defining LOGIC_ACCUM_COUNT_EN.
module logic_accum #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BEATS = 16,
    localparam int unsigned CW       = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_any,
`ifdef LOGIC_ACCUM_COUNT_EN
    output logic [CW-1:0]    out_count,
`endif
    output logic             out_ovf
);

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    localparam logic [1:0] OpOr  = 2'b00;
    localparam logic [1:0] OpAnd = 2'b01;
    localparam logic [1:0] OpXor = 2'b10;
    localparam logic [1:0] OpNor = 2'b11;

    localparam logic [CW-1:0] MaxCnt = CW'(MAX_BEATS);

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       op_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_any_q;
    logic             out_ovf_q;

    logic             beat;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    cnt_inc;
    logic             first_close;
    logic             acc_close;
    logic [WIDTH-1:0] res_first;
    logic [WIDTH-1:0] res_acc;

    always_comb begin
        beat    = in_valid && in_ready_q;
        acc_nxt = acc_q;
        case (op_q)
            OpOr, OpNor: acc_nxt = acc_q | in_data;
            OpAnd:       acc_nxt = acc_q & in_data;
            OpXor:       acc_nxt = acc_q ^ in_data;
            default:     acc_nxt = acc_q;
        endcase
        // Saturating count; never wraps even if MAX_BEATS is a power of two minus one.
        cnt_inc     = (cnt_q == MaxCnt) ? cnt_q : cnt_q + 1'b1;
        first_close = in_last || (MaxCnt == CW'(1));
        acc_close   = in_last || (cnt_inc == MaxCnt);
        res_first   = (op == OpNor) ? ~in_data : in_data;
        res_acc     = (op_q == OpNor) ? ~acc_nxt : acc_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            op_q        <= OpOr;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_any_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (beat) begin
                        acc_q <= in_data;
                        op_q  <= op;
                        cnt_q <= CW'(1);
                        if (first_close) begin
                            state_q     <= StHold;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= res_first;
                            out_any_q   <= |res_first;
                            out_ovf_q   <= ~in_last;
                        end else begin
                            state_q <= StAcc;
                        end
                    end
                end
                StAcc: begin
                    if (beat) begin
                        acc_q <= acc_nxt;
                        cnt_q <= cnt_inc;
                        if (acc_close) begin
                            state_q     <= StHold;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= res_acc;
                            out_any_q   <= |res_acc;
                            out_ovf_q   <= ~in_last;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_any   = out_any_q;
    assign out_ovf   = out_ovf_q;
`ifdef LOGIC_ACCUM_COUNT_EN
    assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_logic_accum.sv
// Scoreboard bench for logic_accum: stimulus pushes expected results, a monitor pops on handshake.
module tb_logic_accum;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned MAX_BEATS = 4;
    localparam int unsigned CW        = $clog2(MAX_BEATS + 1);

    localparam logic [1:0] OR_OP  = 2'b00;
    localparam logic [1:0] AND_OP = 2'b01;
    localparam logic [1:0] XOR_OP = 2'b10;
    localparam logic [1:0] NOR_OP = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_any;
    logic             out_ovf;
`ifdef LOGIC_ACCUM_COUNT_EN
    logic [CW-1:0]    out_count;
`endif

    always #5 clk = ~clk;

    logic_accum #(
        .WIDTH    (WIDTH),
        .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_any  (out_any),
`ifdef LOGIC_ACCUM_COUNT_EN
        .out_count(out_count),
`endif
        .out_ovf  (out_ovf)
    );

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             ovf;
        logic [CW-1:0]    cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_res(input logic [WIDTH-1:0] d, input logic ovf, input int cnt);
        exp_t e;
        e.data = d;
        e.ovf  = ovf;
        e.cnt  = CW'(cnt);
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [WIDTH-1:0] d, input logic l, input logic [1:0] o,
                        output int waits);
        waits    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        op       = o;
        while (!in_ready && waits < 100) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 after %0d cycles, required 1", waits);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_out_any"}, 32'(out_any), 32'd0);
        chk({tag, "_out_ovf"}, 32'(out_ovf), 32'd0);
`ifdef LOGIC_ACCUM_COUNT_EN
        chk({tag, "_out_count"}, 32'(out_count), 32'd0);
`endif
    endtask

    // Monitor: handshake is sampled mid-cycle, inputs change only just after posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got out_data=0x%0h, required no result",
                             out_data);
                end else begin
                    e = sb.pop_front();
                    chk("res_data", 32'(out_data), 32'(e.data));
                    chk("res_any", 32'(out_any), 32'(|e.data));
                    chk("res_ovf", 32'(out_ovf), 32'(e.ovf));
`ifdef LOGIC_ACCUM_COUNT_EN
                    chk("res_count", 32'(out_count), 32'(e.cnt));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        op        = OR_OP;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outputs("reset");

        // OR over three beats, with latency check
        send(8'h01, 1'b0, OR_OP, w);
        send(8'h10, 1'b0, OR_OP, w);
        expect_res(8'h91, 1'b0, 3);
        send(8'h80, 1'b1, OR_OP, w);
        chk("or_latency_valid", 32'(out_valid), 32'd1);
        idle_cycle();

        // AND then XOR back-to-back; mid-packet op changes must be ignored
        send(8'hFF, 1'b0, AND_OP, w);
        send(8'h0F, 1'b0, OR_OP, w);
        expect_res(8'h0C, 1'b0, 3);
        send(8'h3C, 1'b1, XOR_OP, w);
        send(8'hAA, 1'b0, XOR_OP, w);
        chk("gap_between_packets", 32'(w), 32'd1);
        expect_res(8'h55, 1'b0, 2);
        send(8'hFF, 1'b1, AND_OP, w);
        chk("no_gap_mid_packet", 32'(w), 32'd0);
        idle_cycle();

        // Single-beat NOR and OR
        expect_res(8'hFF, 1'b0, 1);
        send(8'h00, 1'b1, NOR_OP, w);
        idle_cycle();
        expect_res(8'h00, 1'b0, 1);
        send(8'h00, 1'b1, OR_OP, w);
        idle_cycle();

        // Forced close at MAX_BEATS; fifth beat waits and opens a new packet
        send(8'h01, 1'b0, OR_OP, w);
        send(8'h02, 1'b0, OR_OP, w);
        send(8'h04, 1'b0, OR_OP, w);
        expect_res(8'h0F, 1'b1, 4);
        send(8'h08, 1'b0, OR_OP, w);
        chk("ovf_valid", 32'(out_valid), 32'd1);
        expect_res(8'h30, 1'b0, 2);
        send(8'h10, 1'b0, OR_OP, w);
        chk("ovf_fifth_waits", 32'(w), 32'd1);
        send(8'h20, 1'b1, OR_OP, w);
        idle_cycle();

        // Back-pressure: result held, pending beat must not be captured
        out_ready = 1'b0;
        expect_res(8'h12, 1'b0, 1);
        send(8'h12, 1'b1, OR_OP, w);
        in_valid = 1'b1;
        in_data  = 8'h40;
        in_last  = 1'b1;
        op       = XOR_OP;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", 32'(out_data), 32'h12);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            if (i < 4) begin
                @(posedge clk);
                #1;
            end
        end
        out_ready = 1'b1;
        expect_res(8'h40, 1'b0, 1);
        send(8'h40, 1'b1, XOR_OP, w);
        chk("bp_release_wait", 32'(w), 32'd1);
        idle_cycle();

        // Reset mid-packet discards it
        send(8'h01, 1'b0, OR_OP, w);
        send(8'h02, 1'b0, OR_OP, w);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outputs("midrst");
        expect_res(8'h33, 1'b0, 1);
        send(8'h33, 1'b1, XOR_OP, w);
        idle_cycle();
        idle_cycle();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_accum.md
# logic_accum

Parametrised, registered successor to our two-input OR gate. Bitwise-reduces a stream of WIDTH-bit words with a selectable operator (OR/AND/XOR/NOR) over a packet delimited by `in_last`. It emits one result word per packet on a valid/ready output. It sits between any producer of flag/status words and a consumer that needs the combined result, e.g. "any lane set" or "all lanes set".

## Interface
- `WIDTH`, 8: data word width, ≥1.
- `MAX_BEATS`, 16: maximum beats per packet before forced termination, ≥1.
- `CW`, derived: $clog2(MAX_BEATS+1); counter width, not user-set.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `op`  in  2  operator: 00 OR, 01 AND, 10 XOR, 11 NOR. Sampled on the first beat of a packet.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  WIDTH  input word.
- `in_last`  in  1  final beat of packet.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  WIDTH  reduced result.
- `out_any`  out  1  reduction-OR of `out_data`.
- `out_ovf`  out  1  packet was force-closed at MAX_BEATS.
- `out_count`  out  CW  beats in packet. Present only with LOGIC_ACCUM_COUNT_EN.

## Operation
- Beat accepted when `in_valid && in_ready`.
- Three states:
  - IDLE: no packet open.
  - ACC: packet open.
  - HOLD: result pending.
- IDLE → ACC on an accepted beat with `in_last=0`. The accumulator loads `in_data` and `op` is latched.
- IDLE → HOLD on an accepted beat with `in_last=1`. This is a single-beat packet; result = `in_data`, inverted for NOR.
- ACC, accepted beat: accumulator ← acc OP `in_data`, using bitwise OR for both OR and NOR, AND, or XOR. Beat counter increments.
- ACC → HOLD on an accepted beat with `in_last=1`, or when the beat count reaches MAX_BEATS.
  - Reaching MAX_BEATS without `in_last` sets `out_ovf=1`.
  - Further beats then start a new packet after HOLD.
- HOLD → IDLE on `out_valid && out_ready`.
- `out_data` = accumulator, bitwise-inverted when the latched op is NOR. Stable throughout HOLD.
- `op` changes mid-packet are ignored; the latched value governs.
- `in_ready` = (state != HOLD). It is a function of registered state only; no combinational path from `out_ready`.
- `out_valid` = (state == HOLD). Registered.
- Beat counter is CW bits wide and saturates at MAX_BEATS; it never wraps.

## Timing
- Reset (`rst=1` at a clock edge) forces state IDLE, accumulator 0, counter 0, latched op 00.
- Reset output values: `in_ready=1`, `out_valid=0`, `out_data=0`, `out_any=0`, `out_ovf=0`, `out_count=0`.
- Reset mid-packet or in HOLD discards the packet; no result is emitted.
- Latency: last beat accepted at edge t, so `out_valid=1` during cycle t+1.
- If `out_ready=1` at t+1, the block is IDLE and `in_ready=1` in cycle t+2.
- Throughput: an N-beat packet occupies N+1 cycles minimum. `in_ready` drops for exactly one cycle when the consumer is always ready.
- Back-pressure: HOLD persists indefinitely while `out_ready=0`, with all outputs stable and `in_ready=0`.
- `in_valid` while `in_ready=0` is ignored. The producer must hold data; it is never dropped or captured.
- `out_ready` asserted while `out_valid=0` has no effect.
- MAX_BEATS=1: every beat is a one-beat packet. `out_ovf` = ~`in_last` of that beat.

## Configuration
- Macro: LOGIC_ACCUM_COUNT_EN.
- Defined: port `out_count` (CW bits) exists. It carries the number of beats accepted in the packet (1..MAX_BEATS), valid while `out_valid=1`, and 0 after reset.
- Undefined: `out_count` port and its output register are absent. The internal beat counter remains for MAX_BEATS termination. All other behaviour is identical.

## Test plan
- Reset then OR, WIDTH=8, `out_ready=1`: beats 0x01, 0x10, 0x80 (last). Required: `out_data=0x91`, `out_any=1`, `out_ovf=0`, `out_count=3`, one cycle after the last beat.
- AND then XOR back-to-back: AND packet 0xFF, 0x0F, 0x3C (last) gives 0x0C. Next packet, XOR 0xAA, 0xFF (last), gives 0x55. Required: `in_ready` low exactly one cycle between packets.
- NOR single beat 0x00 (last): `out_data=0xFF`. Then OR single beat 0x00: `out_data=0x00`, `out_any=0`.
- Overflow, MAX_BEATS=4: five beats 0x01, 0x02, 0x04, 0x08, 0x10 with no `in_last`, OR. Required:
  - first result 0x0F, `out_ovf=1`, `out_count=4`;
  - the fifth beat waits for HOLD to clear and begins a new packet.
- Back-pressure: `out_ready=0` for 5 cycles after the result. Required: `out_valid`/`out_data` stable, `in_ready=0` with `in_valid=1` held, no beat captured. Result is released on the first `out_ready=1`.
- Reset mid-packet: after 2 beats, assert `rst` for one cycle. Required: `out_valid` never asserts for that packet, and all outputs are at reset values the next cycle. A subsequent XOR 0x33 (last) yields 0x33.
